// File: rtl/mul_share_arb.sv
// Round-robin arbiter that shares one pipelined signed multiplier among NUM_REQ requesters.
// Define MUL_SHARE_ARB_SAT_EN to saturate products to the P_WIDTH signed range instead of wrapping.
module mul_share_arb #(
    parameter int NUM_REQ  = 4,
    parameter int A_WIDTH  = 11,
    parameter int B_WIDTH  = 8,
    parameter int P_WIDTH  = 11,
    parameter int LAT      = 2,
    parameter int ID_WIDTH = 2
) (
    input  logic                          ap_clk,
    input  logic                          ap_rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*A_WIDTH-1:0]    req_a,
    input  logic [NUM_REQ*B_WIDTH-1:0]    req_b,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [ID_WIDTH-1:0]           rsp_id,
    output logic [P_WIDTH-1:0]            rsp_p,
    output logic                          busy
);

    localparam int FW = A_WIDTH + B_WIDTH;

    logic [ID_WIDTH-1:0]       ptr;
    logic [LAT-1:0]            stage_valid;
    logic [ID_WIDTH-1:0]       stage_id [LAT];
    logic [P_WIDTH-1:0]        stage_p  [LAT];

    logic                      stall;
    logic                      found;
    logic                      transfer;
    logic [ID_WIDTH-1:0]       grant;
    logic [ID_WIDTH:0]         sum;
    logic signed [A_WIDTH-1:0] op_a;
    logic signed [B_WIDTH-1:0] op_b;
    logic signed [FW-1:0]      full;
    logic [P_WIDTH-1:0]        prod;

    assign stall = stage_valid[LAT-1] & ~rsp_ready;

    // Search upward from ptr with wrap; the first valid requester wins.
    always_comb begin
        found = 1'b0;
        grant = '0;
        sum   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, ptr} + (ID_WIDTH+1)'(k);
            if (sum >= (ID_WIDTH+1)'(NUM_REQ))
                sum = sum - (ID_WIDTH+1)'(NUM_REQ);
            if (!found && req_valid[sum[ID_WIDTH-1:0]]) begin
                found = 1'b1;
                grant = sum[ID_WIDTH-1:0];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (found && !stall && !ap_rst)
            req_ready[grant] = 1'b1;
    end

    assign transfer = |(req_valid & req_ready);

    always_comb begin
        op_a = '0;
        op_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant == ID_WIDTH'(i)) begin
                op_a = req_a[i*A_WIDTH +: A_WIDTH];
                op_b = req_b[i*B_WIDTH +: B_WIDTH];
            end
        end
    end

    assign full = FW'(op_a) * FW'(op_b);

`ifdef MUL_SHARE_ARB_SAT_EN
    localparam logic signed [FW-1:0] P_MAX = FW'({1'b0, {(P_WIDTH-1){1'b1}}});
    localparam logic signed [FW-1:0] P_MIN = {{(FW-P_WIDTH+1){1'b1}}, {(P_WIDTH-1){1'b0}}};

    always_comb begin
        if (full > P_MAX)
            prod = P_MAX[P_WIDTH-1:0];
        else if (full < P_MIN)
            prod = P_MIN[P_WIDTH-1:0];
        else
            prod = full[P_WIDTH-1:0];
    end
`else
    assign prod = full[P_WIDTH-1:0];
`endif

    // Every stage advances together; an idle cycle pushes a bubble into stage 0.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            ptr         <= '0;
            stage_valid <= '0;
            for (int i = 0; i < LAT; i++) begin
                stage_id[i] <= '0;
                stage_p[i]  <= '0;
            end
        end else if (!stall) begin
            stage_valid[0] <= transfer;
            stage_id[0]    <= grant;
            stage_p[0]     <= prod;
            for (int i = 1; i < LAT; i++) begin
                stage_valid[i] <= stage_valid[i-1];
                stage_id[i]    <= stage_id[i-1];
                stage_p[i]     <= stage_p[i-1];
            end
            if (transfer)
                ptr <= (grant == ID_WIDTH'(NUM_REQ-1)) ? '0 : grant + 1'b1;
        end
    end

    assign rsp_valid = stage_valid[LAT-1];
    assign rsp_id    = stage_id[LAT-1];
    assign rsp_p     = stage_p[LAT-1];
    assign busy      = |stage_valid;

endmodule

// File: tb/tb_mul_share_arb.sv
// Directed bench for mul_share_arb: inputs are driven on the falling edge and outputs checked 1ns later.
// Expected products follow MUL_SHARE_ARB_SAT_EN so the same bench covers both builds.
module tb_mul_share_arb;

    localparam int NUM_REQ  = 4;
    localparam int A_WIDTH  = 11;
    localparam int B_WIDTH  = 8;
    localparam int P_WIDTH  = 11;
    localparam int LAT      = 2;
    localparam int ID_WIDTH = 2;

    logic                       ap_clk;
    logic                       ap_rst;
    logic [NUM_REQ-1:0]         req_valid;
    logic [NUM_REQ-1:0]         req_ready;
    logic [NUM_REQ*A_WIDTH-1:0] req_a;
    logic [NUM_REQ*B_WIDTH-1:0] req_b;
    logic                       rsp_valid;
    logic                       rsp_ready;
    logic [ID_WIDTH-1:0]        rsp_id;
    logic [P_WIDTH-1:0]         rsp_p;
    logic                       busy;

    int n_cmp;
    int n_fail;

    mul_share_arb #(
        .NUM_REQ(NUM_REQ), .A_WIDTH(A_WIDTH), .B_WIDTH(B_WIDTH),
        .P_WIDTH(P_WIDTH), .LAT(LAT), .ID_WIDTH(ID_WIDTH)
    ) dut (
        .ap_clk(ap_clk), .ap_rst(ap_rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_p(rsp_p), .busy(busy)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic set_op(input int i, input int a, input int b);
        req_a[i*A_WIDTH +: A_WIDTH] = A_WIDTH'(a);
        req_b[i*B_WIDTH +: B_WIDTH] = B_WIDTH'(b);
    endtask

    task automatic do_reset();
        @(negedge ap_clk);
        req_valid = '0;
        rsp_ready = 1'b1;
        ap_rst    = 1'b1;
        @(negedge ap_clk);
        ap_rst    = 1'b0;
    endtask

    task automatic test_reset();
        ap_rst    = 1'b1;
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        req_a     = '0;
        req_b     = '0;
        @(negedge ap_clk);
        @(negedge ap_clk);
        #1;
        n_cmp++;
        if (req_ready !== 4'b0000) begin
            n_fail++; $display("[TB] FAIL reset_ready: got %b expected %b", req_ready, 4'b0000);
        end
        n_cmp++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("[TB] FAIL reset_valid_busy: got %b%b expected 00", rsp_valid, busy);
        end
        n_cmp++;
        if (rsp_id !== 2'd0 || rsp_p !== 11'd0) begin
            n_fail++; $display("[TB] FAIL reset_data: got id=%0d p=%0h expected id=0 p=0", rsp_id, rsp_p);
        end
        req_valid = '0;
        @(negedge ap_clk);
        ap_rst = 1'b0;
    endtask

    task automatic test_basic();
        @(negedge ap_clk);
        req_valid = 4'b0001;
        set_op(0, 100, 3);
        #1;
        n_cmp++;
        if (req_ready !== 4'b0001) begin
            n_fail++; $display("[TB] FAIL basic_ready: got %b expected %b", req_ready, 4'b0001);
        end
        @(negedge ap_clk);
        req_valid = '0;
        #1;
        n_cmp++;
        if (rsp_valid !== 1'b0 || busy !== 1'b1) begin
            n_fail++; $display("[TB] FAIL basic_inflight: got valid=%b busy=%b expected valid=0 busy=1", rsp_valid, busy);
        end
        @(negedge ap_clk);
        #1;
        n_cmp++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_p !== 11'd300) begin
            n_fail++; $display("[TB] FAIL basic_result: got v=%b id=%0d p=%0d expected v=1 id=0 p=300", rsp_valid, rsp_id, rsp_p);
        end
        @(negedge ap_clk);
        #1;
        n_cmp++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("[TB] FAIL basic_drain: got valid=%b busy=%b expected 0 0", rsp_valid, busy);
        end
    endtask

    task automatic test_wrap();
        int wa [3] = '{1023, -1024, -1024};
        int wb [3] = '{127, -128, 127};
`ifdef MUL_SHARE_ARB_SAT_EN
        int we [3] = '{1023, 1023, -1024};
`else
        int we [3] = '{897, 0, -1024};
`endif
        for (int c = 0; c < 5; c++) begin
            @(negedge ap_clk);
            if (c < 3) begin
                req_valid = 4'b0001;
                set_op(0, wa[c], wb[c]);
            end else begin
                req_valid = '0;
            end
            #1;
            if (c < 3) begin
                n_cmp++;
                if (req_ready !== 4'b0001) begin
                    n_fail++; $display("[TB] FAIL wrap_ready[%0d]: got %b expected 0001", c, req_ready);
                end
            end
            if (c >= 2) begin
                n_cmp++;
                if (rsp_valid !== 1'b1 || rsp_p !== P_WIDTH'(we[c-2])) begin
                    n_fail++; $display("[TB] FAIL wrap_p[%0d]: got v=%b p=%0h expected v=1 p=%0h", c-2, rsp_valid, rsp_p, P_WIDTH'(we[c-2]));
                end
            end
        end
    endtask

    task automatic test_round_robin();
        int rp [4] = '{10, 22, 36, 52};
        logic [NUM_REQ-1:0] exp_r;
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) set_op(i, 10 + i, i + 1);
        for (int c = 0; c < 10; c++) begin
            @(negedge ap_clk);
            req_valid = (c < 8) ? 4'b1111 : 4'b0000;
            #1;
            if (c < 8) begin
                exp_r = 4'(1 << (c % 4));
                n_cmp++;
                if (req_ready !== exp_r) begin
                    n_fail++; $display("[TB] FAIL rr_grant[%0d]: got %b expected %b", c, req_ready, exp_r);
                end
            end
            if (c >= 2) begin
                n_cmp++;
                if (rsp_valid !== 1'b1 || rsp_id !== ID_WIDTH'((c-2) % 4) || rsp_p !== P_WIDTH'(rp[(c-2) % 4])) begin
                    n_fail++; $display("[TB] FAIL rr_rsp[%0d]: got v=%b id=%0d p=%0d expected v=1 id=%0d p=%0d",
                                       c-2, rsp_valid, rsp_id, rsp_p, (c-2) % 4, rp[(c-2) % 4]);
                end
            end
        end
        @(negedge ap_clk);
        #1;
        n_cmp++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("[TB] FAIL rr_drain: got valid=%b busy=%b expected 0 0", rsp_valid, busy);
        end
    endtask

    task automatic test_backpressure();
        logic [3:0] t_rv   [10] = '{4'b1111, 4'b1110, 4'b1100, 4'b1100, 4'b1100,
                                    4'b1100, 4'b1000, 4'b0000, 4'b0000, 4'b0000};
        logic       t_rr   [10] = '{1, 1, 0, 0, 0, 1, 1, 1, 1, 1};
        logic [3:0] t_rdy  [10] = '{4'b0001, 4'b0010, 4'b0000, 4'b0000, 4'b0000,
                                    4'b0100, 4'b1000, 4'b0000, 4'b0000, 4'b0000};
        logic       t_v    [10] = '{0, 0, 1, 1, 1, 1, 1, 1, 1, 0};
        int         t_id   [10] = '{0, 0, 0, 0, 0, 0, 1, 2, 3, 0};
        int         bp_p   [4]  = '{-30, -63, 1000, -900};
        do_reset();
        set_op(0, -5, 6);
        set_op(1, 7, -9);
        set_op(2, 200, 5);
        set_op(3, -300, 3);
        for (int c = 0; c < 10; c++) begin
            @(negedge ap_clk);
            req_valid = t_rv[c];
            rsp_ready = t_rr[c];
            #1;
            n_cmp++;
            if (req_ready !== t_rdy[c]) begin
                n_fail++; $display("[TB] FAIL bp_ready[%0d]: got %b expected %b", c, req_ready, t_rdy[c]);
            end
            n_cmp++;
            if (rsp_valid !== t_v[c]) begin
                n_fail++; $display("[TB] FAIL bp_valid[%0d]: got %b expected %b", c, rsp_valid, t_v[c]);
            end
            if (t_v[c]) begin
                n_cmp++;
                if (rsp_id !== ID_WIDTH'(t_id[c]) || rsp_p !== P_WIDTH'(bp_p[t_id[c]])) begin
                    n_fail++; $display("[TB] FAIL bp_rsp[%0d]: got id=%0d p=%0h expected id=%0d p=%0h",
                                       c, rsp_id, rsp_p, t_id[c], P_WIDTH'(bp_p[t_id[c]]));
                end
            end
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_fail++; $display("[TB] FAIL bp_busy: got %b expected 0", busy);
        end
    endtask

    task automatic test_skip_idle();
        do_reset();
        set_op(0, 2, 2);
        for (int c = 0; c < 8; c++) begin
            @(negedge ap_clk);
            case (c)
                0:       req_valid = 4'b0001;
                4, 5:    req_valid = 4'b1001;
                default: req_valid = 4'b0000;
            endcase
            if (c == 4) begin
                set_op(3, -7, 8);
                set_op(0, 9, 9);
            end
            #1;
            if (c == 0) begin
                n_cmp++;
                if (req_ready !== 4'b0001) begin
                    n_fail++; $display("[TB] FAIL skip_setup: got %b expected 0001", req_ready);
                end
            end
            if (c == 4) begin
                n_cmp++;
                if (req_ready !== 4'b1000) begin
                    n_fail++; $display("[TB] FAIL skip_first: got %b expected 1000", req_ready);
                end
            end
            if (c == 5) begin
                n_cmp++;
                if (req_ready !== 4'b0001) begin
                    n_fail++; $display("[TB] FAIL skip_second: got %b expected 0001", req_ready);
                end
            end
            if (c == 6) begin
                n_cmp++;
                if (rsp_valid !== 1'b1 || rsp_id !== 2'd3 || rsp_p !== P_WIDTH'(-56)) begin
                    n_fail++; $display("[TB] FAIL skip_rsp3: got v=%b id=%0d p=%0h expected v=1 id=3 p=%0h", rsp_valid, rsp_id, rsp_p, P_WIDTH'(-56));
                end
            end
            if (c == 7) begin
                n_cmp++;
                if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_p !== 11'd81) begin
                    n_fail++; $display("[TB] FAIL skip_rsp0: got v=%b id=%0d p=%0d expected v=1 id=0 p=81", rsp_valid, rsp_id, rsp_p);
                end
            end
        end
    endtask

    task automatic test_reset_midflight();
        do_reset();
        set_op(0, 3, 4);
        set_op(1, 5, 6);
        @(negedge ap_clk);
        req_valid = 4'b0011;
        @(negedge ap_clk);
        req_valid = 4'b0010;
        @(negedge ap_clk);
        req_valid = 4'b0000;
        #1;
        n_cmp++;
        if (rsp_valid !== 1'b1 || busy !== 1'b1) begin
            n_fail++; $display("[TB] FAIL mid_inflight: got valid=%b busy=%b expected 1 1", rsp_valid, busy);
        end
        #1;
        ap_rst    = 1'b1;
        req_valid = 4'b0110;
        #1;
        n_cmp++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 4'b0000) begin
            n_fail++; $display("[TB] FAIL mid_async: got valid=%b busy=%b ready=%b expected 0 0 0000", rsp_valid, busy, req_ready);
        end
        @(negedge ap_clk);
        ap_rst = 1'b0;
        #1;
        n_cmp++;
        if (req_ready !== 4'b0010) begin
            n_fail++; $display("[TB] FAIL mid_grant: got %b expected 0010", req_ready);
        end
        @(negedge ap_clk);
        req_valid = '0;
        #1;
        n_cmp++;
        if (rsp_valid !== 1'b0) begin
            n_fail++; $display("[TB] FAIL mid_stale: got %b expected 0", rsp_valid);
        end
        @(negedge ap_clk);
        #1;
        n_cmp++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_p !== 11'd30) begin
            n_fail++; $display("[TB] FAIL mid_result: got v=%b id=%0d p=%0d expected v=1 id=1 p=30", rsp_valid, rsp_id, rsp_p);
        end
        @(negedge ap_clk);
        #1;
        n_cmp++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("[TB] FAIL mid_drain: got valid=%b busy=%b expected 0 0", rsp_valid, busy);
        end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        test_reset();
        test_basic();
        test_wrap();
        test_round_robin();
        test_backpressure();
        test_skip_idle();
        test_reset_midflight();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mul_share_arb.md
Name: mul_share_arb

Overview:
- Shares one signed multiplier (11-bit signed x 8-bit signed -> 11-bit product) among NUM_REQ requesters.
- Multiplier is pipelined; result channel supports backpressure.
- Arbitration is round-robin; each result is tagged with the requester ID.
- Sits between HLS-generated compute loops and a single shared multiplier instance, replacing per-loop multipliers.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- A_WIDTH, 11, signed operand A width.
- B_WIDTH, 8, signed operand B width.
- P_WIDTH, 11, product width delivered on rsp_p.
- LAT, 2, multiplier pipeline depth in cycles (1..4).
- ID_WIDTH, 2, rsp_id width; must equal clog2(NUM_REQ).

Ports:
- ap_clk  in  1  clock, rising edge.
- ap_rst  in  1  asynchronous active-high reset.
- req_valid  in  NUM_REQ  per-requester operand valid.
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- req_a  in  NUM_REQ*A_WIDTH  operand A. Requester i uses bits [i*A_WIDTH +: A_WIDTH].
- req_b  in  NUM_REQ*B_WIDTH  operand B, packed the same way.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  downstream accepts the result.
- rsp_id  out  ID_WIDTH  index of the requester that issued this result.
- rsp_p  out  P_WIDTH  signed product.
- busy  out  1  any pipeline stage holds a valid entry.

Behaviour:
- Reset: ap_clk is the single clock. ap_rst is asynchronous and active-high. While reset is asserted:
  - all stage valid bits clear, so rsp_valid=0 and busy=0;
  - rsp_id=0, rsp_p=0;
  - round-robin pointer = 0.
  - req_ready=0 while ap_rst=1.
- Stall: stall = rsp_valid & ~rsp_ready. The whole pipeline freezes on stall, holding all stage registers. rsp_id and rsp_p stay stable while rsp_valid=1 and rsp_ready=0.
- Grant:
  - When stall=0, grant goes to the first i with req_valid[i]=1, searching from index ptr upward and wrapping modulo NUM_REQ.
  - req_ready[grant]=1; all other bits are 0.
  - When stall=1, or no request is valid, req_ready=0.
  - req_ready may depend combinationally on req_valid. Requesters must not make req_valid depend on req_ready.
- Pointer: on each accepted transfer, ptr <= grant+1 (mod NUM_REQ). With no transfer, ptr is unchanged.
- Transfer: a transfer completes in a cycle where req_valid[i] & req_ready[i] = 1. Operands and ID are captured into stage 1.
- Pipeline:
  - LAT registered stages, each carrying {valid, id, data}. All stages advance together when stall=0.
  - An empty slot (a bubble) enters stage 1 when there is no transfer.
  - Bubbles are not collapsed.
- Latency and throughput:
  - A transfer accepted at edge t produces rsp_valid at edge t+LAT, plus any stall cycles.
  - Throughput is 1 result per cycle when rsp_ready=1.
- Arithmetic:
  - Full product = signed(A) * signed(B), A_WIDTH+B_WIDTH = 19 bits, exact.
  - Default: rsp_p = low P_WIDTH bits of the full product (two's-complement wrap).
  - The product is computed in stage 1; the remaining stages are pure delay.
- Ordering: results leave in acceptance order.
- busy = OR of all stage valid bits.
- Reset mid-operation: in-flight results are discarded with no partial output. After release, the first grant starts search at index 0.
- Simultaneous events: when rsp_ready rises in the same cycle as a new req_valid, the pipeline advances and accepts in that same cycle. Throughput is unaffected.

Optional Feature:
- Macro MUL_SHARE_ARB_SAT_EN.
- Defined: rsp_p saturates to the P_WIDTH signed range instead of wrapping:
  - full > 2^(P_WIDTH-1)-1 -> 1023;
  - full < -2^(P_WIDTH-1) -> -1024.
  - Saturation is applied in stage 1; latency is unchanged.
- Undefined: low-bits wrap as described under Arithmetic.

Test Plan:
1. Basic product: after reset, req_valid=0001, a0=100, b0=3, rsp_ready=1. Required: req_ready=0001 that cycle; 2 cycles later rsp_valid=1, rsp_id=0, rsp_p=300; busy falls the cycle after.
2. Wrap vs saturation:
   - a=1023, b=127 -> rsp_p=897 (wrap), 1023 with SAT_EN.
   - a=-1024, b=-128 -> 0 (wrap), 1023 with SAT_EN.
   - a=-1024, b=127 -> -1024 in both modes.
3. Round-robin fairness: req_valid=1111 held for 8 cycles, rsp_ready=1. Required: grant order 0,1,2,3,0,1,2,3; rsp_id in the same order; one result per cycle after 2-cycle latency.
4. Backpressure: stream 4 requests, drop rsp_ready for 3 cycles while rsp_valid=1. Required:
   - req_ready=0000 and rsp_id/rsp_p held stable during the stall;
   - all 4 results delivered in order with none lost or duplicated after rsp_ready returns.
5. Skip idle requesters: ptr=1, req_valid=1001. Required: grant 3 first, then 0.
6. Reset mid-flight: assert ap_rst asynchronously with 2 results in flight. Required: rsp_valid=0 and busy=0 immediately (without a clock edge); no stale results after release; next grant with req_valid=0110 goes to requester 1.
